alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded RV32I integer op to an external combinational ALU and returns one response.
// Latency: LUI/illegal 1 cycle, plain ALU ops 2 cycles, SLT/SLTU/SRA/branch 3 cycles from accept edge to rsp_valid.
// Backpressure: one op in flight; req_ready is low until the response is taken, and rsp_* hold while rsp_ready is low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake; opcode, funct3, funct7b5, rs1_val, rs2_val, imm, pc
//   alu_in1, alu_in2, alu_sel       drive the combinational ALU (alu_sel = IDLE_SEL outside EXEC)
//   alu_out, alu_zero               ALU result and compare flags (100 less, 010 equal, 001 greater)
//   rsp_valid/rsp_ready             response handshake; rsp_result, rsp_taken, rsp_illegal
module alu_issue_ctrl #(
  parameter logic [3:0] IDLE_SEL = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic [2:0]  alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_taken,
  output logic        rsp_illegal
);

  // RV32I major opcodes handled here
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ALU select encodings
  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_CMP  = 4'b0111;
  localparam logic [3:0] SEL_CMPU = 4'b1000;
  localparam logic [3:0] SEL_SLL  = 4'b1001;
  localparam logic [3:0] SEL_SRL  = 4'b1011;
  localparam logic [3:0] SEL_XOR  = 4'b1100;

  localparam logic [2:0] FLAG_LT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_RESOLVE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched request fields
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_imm;
  logic [31:0] r_pc;

  // Captured ALU outputs / response registers
  logic [2:0]  r_flags;
  logic [31:0] r_result;
  logic        r_taken;
  logic        r_illegal;

  // Decode of the incoming request (used only in IDLE)
  logic w_req_lui;
  logic w_req_illegal;

  // Decode of the latched request (used in EXEC/RESOLVE)
  logic [3:0]  w_sel;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_resolve;
  logic        w_is_branch;
  logic        w_is_slt;
  logic        w_lt;
  logic        w_eq;
  logic        w_taken;

  // ---------------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------------
  always_comb begin
    w_req_lui     = (opcode == OPC_LUI);
    w_req_illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_AUIPC, OPC_LUI: w_req_illegal = 1'b0;
      // funct3 010/011 have no branch meaning
      OPC_BRANCH: w_req_illegal = (funct3[2:1] == 2'b01);
      default:    w_req_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU select and operand choice from latched fields
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel     = SEL_ADD;
    w_op1     = r_rs1;
    w_op2     = r_rs2;
    w_resolve = 1'b0;
    case (r_opcode)
      OPC_AUIPC: begin
        w_op1 = r_pc;
        w_op2 = r_imm;
        w_sel = SEL_ADD;
      end
      OPC_BRANCH: begin
        // BLTU/BGEU (11x) compare unsigned, the rest signed
        w_sel     = (r_funct3[2:1] == 2'b11) ? SEL_CMPU : SEL_CMP;
        w_resolve = 1'b1;
      end
      OPC_OP, OPC_OPIMM: begin
        if (r_opcode == OPC_OPIMM) begin
          w_op2 = r_imm;
        end
        case (r_funct3)
          3'b000: w_sel = ((r_opcode == OPC_OP) && r_funct7b5) ? SEL_SUB : SEL_ADD;
          3'b001: w_sel = SEL_SLL;
          3'b010: begin
            w_sel     = SEL_CMP;
            w_resolve = 1'b1;
          end
          3'b011: begin
            w_sel     = SEL_CMPU;
            w_resolve = 1'b1;
          end
          3'b100: w_sel = SEL_XOR;
          3'b101: begin
            // ALU only shifts logically; SRA is sign-filled in RESOLVE
            w_sel     = SEL_SRL;
            w_resolve = r_funct7b5;
          end
          3'b110: w_sel = SEL_OR;
          3'b111: w_sel = SEL_AND;
        endcase
      end
      default: begin
        w_sel     = SEL_ADD;
        w_resolve = 1'b0;
      end
    endcase
  end

  assign w_is_branch = (r_opcode == OPC_BRANCH);
  assign w_is_slt    = ((r_opcode == OPC_OP) || (r_opcode == OPC_OPIMM)) && (r_funct3[2:1] == 2'b01);

  // Any flag pattern other than exactly 100/010 counts as "not less, not equal"
  assign w_lt = (r_flags == FLAG_LT);
  assign w_eq = (r_flags == FLAG_EQ);

  always_comb begin
    case (r_funct3)
      3'b000:         w_taken = w_eq;
      3'b001:         w_taken = !w_eq;
      3'b100, 3'b110: w_taken = w_lt;
      default:        w_taken = !w_lt;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = (w_req_lui || w_req_illegal) ? S_RESP : S_EXEC;
        end
      end
      S_EXEC:    w_next = w_resolve ? S_RESOLVE : S_RESP;
      S_RESOLVE: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_sel     = IDLE_SEL;
    alu_in1     = '0;
    alu_in2     = '0;
    rsp_result  = '0;
    rsp_taken   = 1'b0;
    rsp_illegal = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_EXEC: begin
        alu_sel = w_sel;
        alu_in1 = w_op1;
        alu_in2 = w_op2;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_result  = r_result;
        rsp_taken   = r_taken;
        rsp_illegal = r_illegal;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_flags    <= '0;
      r_result   <= '0;
      r_taken    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_opcode   <= opcode;
            r_funct3   <= funct3;
            r_funct7b5 <= funct7b5;
            r_rs1      <= rs1_val;
            r_rs2      <= rs2_val;
            r_imm      <= imm;
            r_pc       <= pc;
            r_flags    <= '0;
            r_taken    <= 1'b0;
            r_illegal  <= w_req_illegal;
            // LUI bypasses the ALU; illegal responses carry zero
            r_result   <= w_req_lui ? imm : 32'd0;
          end
        end
        S_EXEC: begin
          r_result <= alu_out;
          r_flags  <= alu_zero;
        end
        S_RESOLVE: begin
          if (w_is_branch) begin
            r_result <= '0;
            r_taken  <= w_taken;
          end else if (w_is_slt) begin
            r_result <= {31'd0, w_lt};
          end else if (r_rs1[31]) begin
            // SRA of a negative value: fill the vacated top bits with ones
            r_result <= r_result | ~(32'hFFFF_FFFF >> w_op2[4:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a behavioural model.
// Latency: not applicable (testbench).
// Backpressure: the bench stalls rsp_ready for random and fixed numbers of cycles.
module tb_alu_issue_ctrl;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic [2:0]  alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_taken;
  logic        rsp_illegal;

  // Forces the ALU compare flags to an out-of-range pattern
  bit          ovr_en;
  logic [2:0]  ovr_flags;

  int n_checks;
  int n_errors;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in
  always_comb begin
    alu_out  = 32'd0;
    alu_zero = 3'b000;
    case (alu_sel)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b1001: alu_out = alu_in1 << alu_in2[4:0];
      4'b1011: alu_out = alu_in1 >> alu_in2[4:0];
      4'b1100: alu_out = alu_in1 ^ alu_in2;
      4'b0111: begin
        if (ovr_en) alu_zero = ovr_flags;
        else if ($signed(alu_in1) < $signed(alu_in2)) alu_zero = 3'b100;
        else if (alu_in1 == alu_in2) alu_zero = 3'b010;
        else alu_zero = 3'b001;
      end
      4'b1000: begin
        if (ovr_en) alu_zero = ovr_flags;
        else if (alu_in1 < alu_in2) alu_zero = 3'b100;
        else if (alu_in1 == alu_in2) alu_zero = 3'b010;
        else alu_zero = 3'b001;
      end
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural expectation for one instruction, straight from the RV32I meaning
  task automatic model(
    input  logic [6:0]  op, input logic [2:0] f3, input logic f7,
    input  logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
    input  bit          ovr,
    output logic [31:0] res, output bit tk, output bit il, output int lat,
    output bit          use_alu, output logic [3:0] sel,
    output logic [31:0] i1, output logic [31:0] i2);
    logic [31:0] o2;
    bit lt, eq;
    res = 32'd0; tk = 0; il = 0; lat = 2; use_alu = 1; sel = 4'hF; i1 = a; i2 = b;
    case (op)
      LUI: begin res = im; lat = 1; use_alu = 0; end
      AUIPC: begin i1 = p; i2 = im; sel = 4'b0010; res = p + im; end
      OP, OPIMM: begin
        o2 = (op == OP) ? b : im;
        i2 = o2;
        case (f3)
          3'd0: if (op == OP && f7) begin sel = 4'b0110; res = a - o2; end
                else begin sel = 4'b0010; res = a + o2; end
          3'd1: begin sel = 4'b1001; res = a << o2[4:0]; end
          3'd2: begin sel = 4'b0111; lat = 3;
                  res = (!ovr && ($signed(a) < $signed(o2))) ? 32'd1 : 32'd0; end
          3'd3: begin sel = 4'b1000; lat = 3;
                  res = (!ovr && (a < o2)) ? 32'd1 : 32'd0; end
          3'd4: begin sel = 4'b1100; res = a ^ o2; end
          3'd5: begin
            sel = 4'b1011;
            if (f7) begin res = $signed(a) >>> o2[4:0]; lat = 3; end
            else res = a >> o2[4:0];
          end
          3'd6: begin sel = 4'b0001; res = a | o2; end
          default: begin sel = 4'b0000; res = a & o2; end
        endcase
      end
      BRANCH: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          il = 1; lat = 1; use_alu = 0;
        end else begin
          lat = 3;
          sel = (f3 >= 3'd6) ? 4'b1000 : 4'b0111;
          lt = (f3 >= 3'd6) ? (a < b) : ($signed(a) < $signed(b));
          eq = (a == b);
          if (ovr) begin lt = 0; eq = 0; end
          case (f3)
            3'd0: tk = eq;
            3'd1: tk = !eq;
            3'd4, 3'd6: tk = lt;
            default: tk = !lt;
          endcase
        end
      end
      default: begin il = 1; lat = 1; use_alu = 0; end
    endcase
  endtask

  // Runs one transaction from IDLE to response acceptance; called at a negedge with the DUT idle
  task automatic run_txn(
    input  logic [6:0] op, input logic [2:0] f3, input logic f7,
    input  logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
    input  bit ovr, input logic [2:0] ovf, input int hold,
    output logic [31:0] o_res, output bit o_tk, output bit o_il, output int o_lat, output logic [3:0] o_sel);
    logic [31:0] e_res, e_i1, e_i2;
    bit e_tk, e_il, e_alu, got;
    int e_lat;
    logic [3:0] e_sel;
    model(op, f3, f7, a, b, im, p, ovr, e_res, e_tk, e_il, e_lat, e_alu, e_sel, e_i1, e_i2);
    o_res = 'x; o_tk = 0; o_il = 0; o_lat = 0; o_sel = 4'hF;
    ovr_en = ovr; ovr_flags = ovf;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_alu_sel", 32'(alu_sel), 32'hF);
    opcode = op; funct3 = f3; funct7b5 = f7; rs1_val = a; rs2_val = b; imm = im; pc = p;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    opcode = 7'($urandom); rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; pc = $urandom;
    got = 0;
    for (int k = 1; k <= 6 && !got; k++) begin
      if (rsp_valid) begin
        got = 1; o_lat = k;
      end else begin
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (k == 1 && e_alu) begin
          o_sel = alu_sel;
          chk("exec_alu_sel", 32'(alu_sel), 32'(e_sel));
          chk("exec_alu_in1", alu_in1, e_i1);
          chk("exec_alu_in2", alu_in2, e_i2);
        end else begin
          chk("nonexec_alu_sel", 32'(alu_sel), 32'hF);
        end
        @(negedge clk);
      end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL rsp_timeout: no rsp_valid within 6 cycles, op %b f3 %0d", op, f3);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; ovr_en = 0;
      return;
    end
    o_res = rsp_result; o_tk = rsp_taken; o_il = rsp_illegal;
    chk("rsp_latency", 32'(o_lat), 32'(e_lat));
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_taken", 32'(rsp_taken), 32'(e_tk));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(e_il));
    chk("rsp_req_ready", 32'(req_ready), 32'd0);
    chk("rsp_alu_sel", 32'(alu_sel), 32'hF);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, o_res);
      chk("stall_taken", 32'(rsp_taken), 32'(o_tk));
      chk("stall_illegal", 32'(rsp_illegal), 32'(o_il));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    ovr_en = 0;
  endtask

  logic [31:0] r_res;
  bit          r_tk, r_il;
  int          r_lat;
  logic [3:0]  r_sel;

  initial begin
    logic [6:0] op;
    logic [2:0] f3, ovf;
    logic       f7;
    logic [31:0] a, b, im;
    bit cmp, ovr;

    n_checks = 0; n_errors = 0;
    ovr_en = 0; ovr_flags = 3'b000;
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_taken", 32'(rsp_taken), 32'd0);
    chk("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
    chk("reset_alu_in1", alu_in1, 32'd0);
    chk("reset_alu_in2", alu_in2, 32'd0);
    chk("reset_alu_sel", 32'(alu_sel), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed cases
    run_txn(OP, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("add_result", r_res, 32'd12); chk("add_lat", 32'(r_lat), 32'd2); chk("add_sel", 32'(r_sel), 32'b0010);
    chk("add_illegal", 32'(r_il), 32'd0);
    run_txn(OP, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("slt_result", r_res, 32'd1); chk("slt_lat", 32'(r_lat), 32'd3); chk("slt_sel", 32'(r_sel), 32'b0111);
    run_txn(OP, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("sltu_result", r_res, 32'd0); chk("sltu_lat", 32'(r_lat), 32'd3); chk("sltu_sel", 32'(r_sel), 32'b1000);
    run_txn(OP, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("sra_result", r_res, 32'hF800_0000);
    run_txn(OP, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("srl_result", r_res, 32'h0800_0000);
    run_txn(BRANCH, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("beq_taken", 32'(r_tk), 32'd1); chk("beq_result", r_res, 32'd0);
    run_txn(BRANCH, 3'd1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("bne_taken", 32'(r_tk), 32'd0);
    run_txn(BRANCH, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("bltu_taken", 32'(r_tk), 32'd1);
    run_txn(BRANCH, 3'd4, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("blt_taken", 32'(r_tk), 32'd0);
    run_txn(7'b0000011, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 32'd0, 0, 3'd0, 4, r_res, r_tk, r_il, r_lat, r_sel);
    chk("illegal_flag", 32'(r_il), 32'd1); chk("illegal_result", r_res, 32'd0);
    chk("illegal_lat", 32'(r_lat), 32'd1);
    run_txn(BRANCH, 3'd3, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("branch_f3_011_illegal", 32'(r_il), 32'd1);
    run_txn(LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("lui_result", r_res, 32'h1234_5000); chk("lui_lat", 32'(r_lat), 32'd1);
    run_txn(AUIPC, 3'd0, 1'b0, 32'd0, 32'd0, 32'h20, 32'h1000, 0, 3'd0, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("auipc_result", r_res, 32'h1020);
    // Out-of-range flags read as "not less, not equal"
    run_txn(BRANCH, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 1, 3'b111, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("beq_badflags_taken", 32'(r_tk), 32'd0);
    run_txn(BRANCH, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1, 3'b000, 0, r_res, r_tk, r_il, r_lat, r_sel);
    chk("bge_badflags_taken", 32'(r_tk), 32'd1);

    // Reset during EXEC
    opcode = OP; funct3 = 3'd2; funct7b5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midreset_exec_sel", 32'(alu_sel), 32'b0111);
    rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_alu_sel", 32'(alu_sel), 32'hF);
    chk("midreset_alu_in1", alu_in1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postreset_no_rsp", 32'(rsp_valid), 32'd0);
      chk("postreset_req_ready", 32'(req_ready), 32'd1);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP;
        3, 4, 5: op = OPIMM;
        6, 7:    op = BRANCH;
        8:       op = ($urandom_range(0, 1) == 0) ? AUIPC : LUI;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) begin a = $urandom_range(0, 40); b = $urandom_range(0, 40); end
      im = $urandom;
      cmp = (op == BRANCH && f3 != 3'd2 && f3 != 3'd3) ||
            ((op == OP || op == OPIMM) && (f3 == 3'd2 || f3 == 3'd3));
      ovr = cmp && ($urandom_range(0, 7) == 0);
      ovf = 3'($urandom);
      if (ovf == 3'b100 || ovf == 3'b010 || ovf == 3'b001) ovf = 3'b111;
      run_txn(op, f3, f7, a, b, im, $urandom, ovr, ovf, $urandom_range(0, 2),
              r_res, r_tk, r_il, r_lat, r_sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
